// File: rtl/led_trail_pwm.sv
// Comet-trail LED renderer: one-hot position loads full brightness, others decay, shared PWM.
// Optional end-of-sweep full-on flash frame is built when TC_FLASH_EN is defined.
module led_trail_pwm #(
   parameter int unsigned N     = 8,
   parameter int unsigned BW    = 4,
   parameter int unsigned DECAY = 4
) (
   input  logic         clk,
   input  logic         rstna,
   input  logic         step,
   input  logic [N-1:0] pos,
   input  logic         tc,
   input  logic         clr_err,
   output logic [N-1:0] led,
   output logic         frame_sync,
   output logic         onehot_err
);

   localparam logic [BW-1:0] MAX = '1;

   logic [BW-1:0] pwm_cnt;
   logic [BW-1:0] shadow     [N];
   logic [BW-1:0] shadow_nxt [N];
   logic [BW-1:0] disp       [N];
   logic [N-1:0]  led_nxt;
   logic          boundary;
   logic          pos_ok;
   logic          force_on;

   function automatic logic [BW-1:0] decay_sat(input logic [BW-1:0] v);
      if (32'(v) > DECAY) return BW'(32'(v) - DECAY);
      else                return '0;
   endfunction

   assign boundary   = (pwm_cnt == MAX);
   assign frame_sync = boundary;
   assign pos_ok     = (pos != '0) && ((pos & (pos - N'(1))) == '0);

   always_ff @(posedge clk or negedge rstna) begin
      if (!rstna) pwm_cnt <= '0;
      else        pwm_cnt <= pwm_cnt + BW'(1);
   end

   always_comb begin
      for (int unsigned i = 0; i < N; i++) begin
         shadow_nxt[i] = shadow[i];
         if (step) begin
            if (pos_ok && pos[i]) shadow_nxt[i] = MAX;
            else                  shadow_nxt[i] = decay_sat(shadow[i]);
         end
      end
   end

   // disp samples the pre-step shadow when a step lands on the boundary edge
   always_ff @(posedge clk or negedge rstna) begin
      if (!rstna) begin
         for (int unsigned i = 0; i < N; i++) begin
            shadow[i] <= '0;
            disp[i]   <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < N; i++) begin
            shadow[i] <= shadow_nxt[i];
            if (boundary) disp[i] <= shadow[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rstna) begin
      if (!rstna)              onehot_err <= 1'b0;
      else if (step && !pos_ok) onehot_err <= 1'b1;
      else if (clr_err)        onehot_err <= 1'b0;
   end

`ifdef TC_FLASH_EN
   typedef enum logic [1:0] {FL_IDLE, FL_ARMED, FL_ON} flash_t;
   flash_t fl_q, fl_d;

   always_ff @(posedge clk or negedge rstna) begin
      if (!rstna) fl_q <= FL_IDLE;
      else        fl_q <= fl_d;
   end

   // tc is only honoured from idle, so pulses while armed or on coalesce
   always_comb begin
      fl_d     = fl_q;
      force_on = 1'b0;
      case (fl_q)
         FL_IDLE:  if (tc) fl_d = FL_ARMED;
         FL_ARMED: if (boundary) fl_d = FL_ON;
         FL_ON: begin
            force_on = 1'b1;
            if (boundary) fl_d = FL_IDLE;
         end
         default:  fl_d = FL_IDLE;
      endcase
   end
`else
   logic unused_tc;
   assign unused_tc = tc;
   assign force_on  = 1'b0;
`endif

   always_comb begin
      led_nxt = '0;
      for (int unsigned i = 0; i < N; i++) led_nxt[i] = (pwm_cnt < disp[i]);
      if (force_on) led_nxt = '1;
   end

   always_ff @(posedge clk or negedge rstna) begin
      if (!rstna) led <= '0;
      else        led <= led_nxt;
   end

endmodule
